// File: rtl/div_5bit_seq.sv
// Sequential 5-bit unsigned restoring divider: one quotient bit per clock,
// trial subtraction as R + ~D + 1 with the carry-out acting as not-borrow.
module div_5bit_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] dividend,
    input  logic [4:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [4:0] quotient,
    output logic [4:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [5:0] r;
    logic [4:0] q;
    logic [4:0] d;
    logic [2:0] cnt;
    logic       dbz;

    logic [5:0] s;
    logic [5:0] t;
    logic       c6;

    // r stays below d, so dropping r[5] in the shift never loses information
    always_comb begin
        s       = 6'({r, q[4]});
        {c6, t} = {1'b0, s} + {1'b0, 1'b1, ~d} + 7'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 3'd0) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= 6'd0;
            q           <= 5'd0;
            d           <= 5'd0;
            cnt         <= 3'd0;
            dbz         <= 1'b0;
            quotient    <= 5'd0;
            remainder   <= 5'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != 5'd0) begin
                            q   <= dividend;
                            d   <= divisor;
                            r   <= 6'd0;
                            cnt <= 3'd4;
                            dbz <= 1'b0;
                        end else begin
                            // zero divisor skips iteration and publishes at once
                            dbz         <= 1'b1;
                            quotient    <= 5'h1F;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r   <= c6 ? t : s;
                    q   <= {q[3:0], c6};
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        quotient    <= {q[3:0], c6};
                        remainder   <= c6 ? t[4:0] : s[4:0];
                        div_by_zero <= dbz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_5bit_seq.sv
// Bench for div_5bit_seq: arithmetic reference model with a cycle-level
// busy/done schedule, per-cycle compare process and directed scenarios.
module tb_div_5bit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    // expected {div_by_zero, quotient, remainder}, one entry per completed op
    logic [10:0] exp_q[$];
    logic [10:0] held_exp;
    logic [10:0] pending;
    int          m_left;

    div_5bit_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [10:0] ref_div(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] qq;
        logic [4:0] rr;
        if (b == 5'd0) return {1'b1, 5'h1F, a};
        qq = a / b;
        rr = a % b;
        return {1'b0, qq, rr};
    endfunction

    // m_left counts the cycles the operation still occupies after an edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   = 0;
            held_exp = '0;
            pending  = '0;
            exp_q.delete();
        end else begin
            if (m_left == 0) begin
                if (start) begin
                    m_left  = (divisor == 5'd0) ? 1 : 6;
                    pending = ref_div(dividend, divisor);
                end
            end else begin
                m_left = m_left - 1;
            end
            if (m_left == 1) begin
                held_exp = pending;
                exp_q.push_back(pending);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] got;
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("done", 32'(done), 32'(m_left == 1));
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk("result", 32'({div_by_zero, quotient, remainder}), 32'(got));
                end
            end else begin
                chk("held", 32'({div_by_zero, quotient, remainder}), 32'(held_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 5'($urandom_range(0, 31));
        divisor  = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_done(input int max, output int n);
        n = 1;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [4:0] a, input logic [4:0] b, output logic [10:0] res);
        int n;
        start_op(a, b);
        wait_done(10, n);
        chk("latency", 32'(n), (b == 5'd0) ? 32'd1 : 32'd6);
        res = {div_by_zero, quotient, remainder};
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [10:0] res;
        int          done_at;
        int          done_cnt;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 5'd0;
        divisor  = 5'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, div_by_zero, quotient, remainder}), 32'd0);
        rst = 1'b0;

        // model pins
        chk("model_23_5", 32'(ref_div(5'd23, 5'd5)), 32'({1'b0, 5'd4, 5'd3}));
        chk("model_0_0", 32'(ref_div(5'd0, 5'd0)), 32'({1'b1, 5'h1F, 5'd0}));
        chk("model_31_31", 32'(ref_div(5'd31, 5'd31)), 32'({1'b0, 5'd1, 5'd0}));

        run_op(5'd23, 5'd5, res);
        chk("r23_5", 32'(res), 32'({1'b0, 5'd4, 5'd3}));
        @(negedge clk);
        chk("busy_low_after_done", 32'(busy), 32'd0);

        // back-to-back: second start lands in the idle cycle after done
        run_op(5'd31, 5'd1, res);
        chk("r31_1", 32'(res), 32'({1'b0, 5'd31, 5'd0}));
        run_op(5'd3, 5'd9, res);
        chk("r3_9", 32'(res), 32'({1'b0, 5'd0, 5'd3}));

        run_op(5'd7, 5'd0, res);
        chk("r7_0", 32'(res), 32'({1'b1, 5'h1F, 5'd7}));
        run_op(5'd12, 5'd4, res);
        chk("r12_4", 32'(res), 32'({1'b0, 5'd3, 5'd0}));

        // starts during RUN and DONE must be ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 5'd23;
        divisor  = 5'd5;
        done_at  = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done && done_at < 0) begin
                done_at = i;
                res     = {div_by_zero, quotient, remainder};
            end
            start    = 1'b1;
            dividend = 5'd1;
            divisor  = 5'd1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_done_at", 32'(done_at), 32'd5);
        chk("ignored_start_result", 32'(res), 32'({1'b0, 5'd4, 5'd3}));
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of an operation
        start_op(5'd29, 5'd3);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'({busy, done, div_by_zero, quotient, remainder}), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("no_done_after_abort", 32'(done_cnt), 32'd0);
        run_op(5'd29, 5'd3, res);
        chk("r29_3", 32'(res), 32'({1'b0, 5'd9, 5'd2}));

        // exhaustive sweep
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                run_op(5'(a), 5'(b), res);
                chk("sweep", 32'(res), 32'(ref_div(5'(a), 5'(b))));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
